inst_fetch_resp: RTL and testbench
==================================

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 Parameter INST_MEM_DEPTH, 1024, number of 32-bit instruction words held; power of two.
REQ-002 Parameter INST_ADDR_W, 10, word-address width, log2(INST_MEM_DEPTH).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  fetch enable from the PC stage; high = fetch requested.
REQ-006 pc  input  32  byte address of the requested instruction.
REQ-007 inst  output  32  fetched instruction word.
REQ-008 inst_valid  output  1  inst holds the response to the previous cycle's request.
REQ-009 addr_err  output  1  previous cycle's request was misaligned or out of range.
REQ-010 load_en  input  1  program-load session request.
REQ-011 load_valid  input  1  load_byte is valid this cycle.
REQ-012 load_byte  input  8  program byte, big-endian order within each word.
REQ-013 load_ready  output  1  byte is accepted when load_valid && load_ready.
REQ-014 load_done  output  1  one-cycle pulse at end of load session.

Function
REQ-015 FSM states IDLE, LOAD, SERVE; the state register resets to IDLE.
REQ-016 IDLE: load_en=1 -> LOAD (load_en has priority); else ce=1 -> SERVE and the current cycle's request is serviced; else stay.
REQ-017 LOAD: load_ready=1; each accepted byte shifts into a 32-bit assembly register, first byte landing in bits [31:24].
REQ-018 LOAD: on the 4th accepted byte, the assembled word is written to mem[wr_ptr] in that cycle, wr_ptr increments, and the byte count clears.
REQ-019 wr_ptr wraps from INST_MEM_DEPTH-1 to 0 with no error indication.
REQ-020 LOAD with load_en=0: a partial word (1-3 bytes) is zero-padded in the low bytes and written to mem[wr_ptr]; load_done=1 for one cycle; wr_ptr and byte count clear; next state IDLE.
REQ-021 load_ready=0 in IDLE and SERVE; load_valid outside LOAD is ignored.
REQ-022 SERVE: each cycle with ce=1, the request is registered; one cycle later inst=mem[pc[INST_ADDR_W+1:2]], inst_valid=1, addr_err=0 (fixed latency 1).
REQ-023 pc[1:0]!=0 or pc[31:INST_ADDR_W+2]!=0: one cycle later inst=32'h00000000 (NOP), inst_valid=1, addr_err=1.
REQ-024 SERVE with ce=0: one cycle later inst=0, inst_valid=0, addr_err=0; next state IDLE.
REQ-025 load_en in SERVE is ignored until the FSM returns to IDLE.
REQ-026 Fetches in consecutive cycles are fully pipelined, one response per cycle, no bubbles.
REQ-027 Memory read and write are both synchronous; reads and writes never occur in the same cycle, because LOAD and SERVE are exclusive.

Reset
REQ-028 rst=1: state=IDLE; inst=0, inst_valid=0, addr_err=0, load_ready=0, load_done=0; wr_ptr=0; byte count=0; assembly register=0.
REQ-029 Memory contents are not cleared by reset; reset during LOAD discards the partial word without writing it and produces no load_done.
REQ-030 Reset during SERVE suppresses the pending response; inst_valid=0 in the cycle after reset is released.

Structure
REQ-031 State encodings, INST_MEM_DEPTH default, and the NOP constant live in the shared defines file alongside the existing bus-width and chip-enable macros.
REQ-032 The memory array is a sub-module inst_mem_sp (single-port synchronous RAM, one write or one read per cycle); the FSM, assembly logic, and response registers reside in inst_fetch_resp.

Verification
REQ-033 Load bytes 3C,01,00,10,34,21,00,01 then drop load_en -> mem[0]=3C010010, mem[1]=34210001, load_done pulses once.
REQ-034 After REQ-033, ce=1 with pc=0,4,8 on consecutive cycles -> inst=3C010010, 34210001, 0 on the next three cycles; inst_valid=1 and addr_err=0 on each.
REQ-035 pc=32'h00000002 -> inst=0, addr_err=1; pc=32'h00001000 (depth 1024) -> inst=0, addr_err=1.
REQ-036 Load 6 bytes AA,BB,CC,DD,EE,FF then end session -> mem[0]=AABBCCDD, mem[1]=EEFF0000.
REQ-037 rst after 2 bytes of a load -> mem unchanged, no load_done; a subsequent session starts writing at mem[0].
REQ-038 load_en=1 while ce=1 in SERVE -> load_ready stays 0 and fetch responses continue; after ce=0, FSM passes through IDLE into LOAD.

Source files
------------

// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction fetch/response block.
//   - bus width and chip-enable polarity used across the fetch path
//   - default instruction memory depth
//   - NOP word returned for faulting fetches
//   - FSM state encoding
package inst_fetch_resp_pkg;

    localparam int           IFR_BUS_W     = 32;
    localparam logic         IFR_CE_ACTIVE = 1'b1;
    localparam int           IFR_MEM_DEPTH = 1024;
    localparam logic [31:0]  IFR_NOP       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } ifr_state_t;

endpackage

// File: rtl/inst_mem_sp.sv
// Single-port synchronous instruction RAM.
// One access per cycle: a write when we=1, otherwise a read when re=1.
// Read data is registered (one cycle latency) and holds between reads.
// Ports:
//   clk   - clock
//   we    - write enable
//   re    - read enable (ignored when we=1)
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
// Contents are deliberately not reset.
module inst_mem_sp #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder with a byte-serial program loader.
// A load session (load_en) streams bytes in big-endian order into words
// that are written sequentially from address 0; a serve session answers
// one fetch per cycle with a fixed one-cycle latency.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   ce, pc             - fetch request (byte address)
//   inst, inst_valid   - response to the previous cycle's request
//   addr_err           - previous request was misaligned or out of range
//   load_en            - program-load session request
//   load_valid/_byte   - byte stream, accepted when load_ready=1
//   load_ready         - high while in the load state
//   load_done          - one-cycle pulse after a session ends
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int INST_MEM_DEPTH = IFR_MEM_DEPTH,
    parameter int INST_ADDR_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        addr_err,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        load_done
);

    localparam logic [INST_ADDR_W-1:0] PTR_ONE = {{(INST_ADDR_W-1){1'b0}}, 1'b1};

    ifr_state_t             state_q, state_d;
    logic [INST_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [31:0]            asm_q, asm_d;
    logic                   req_valid_q, req_valid_d;
    logic                   req_err_q, req_err_d;
    logic                   load_done_q, load_done_d;

    logic                   byte_acc;
    logic [2:0]             cnt_new;
    logic [31:0]            asm_new;
    logic [31:0]            asm_pad;
    logic                   fetch;
    logic                   fetch_err;
    logic                   mem_we;
    logic                   mem_re;
    logic [INST_ADDR_W-1:0] mem_addr;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;

    // Misaligned or beyond the populated word range.
    assign fetch_err = (pc[1:0] != 2'b00) || (pc[31:INST_ADDR_W+2] != '0);

    // A byte presented in the closing cycle of a session is still taken
    // and folded into the final (possibly partial) word.
    assign byte_acc = (state_q == ST_LOAD) && load_valid;
    assign cnt_new  = {1'b0, cnt_q} + {2'b00, byte_acc};
    assign asm_new  = byte_acc ? {asm_q[23:0], load_byte} : asm_q;

    // Move a partial word's bytes up so the missing low bytes read as zero.
    always_comb begin
        asm_pad = asm_new;
        case (cnt_new)
            3'd1:    asm_pad = {asm_new[7:0],  24'h000000};
            3'd2:    asm_pad = {asm_new[15:0], 16'h0000};
            3'd3:    asm_pad = {asm_new[23:0], 8'h00};
            default: asm_pad = asm_new;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        load_done_d = 1'b0;
        fetch       = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = asm_new;

        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    state_d = ST_LOAD;
                end else if (ce == IFR_CE_ACTIVE) begin
                    state_d = ST_SERVE;
                    fetch   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!load_en) begin
                    state_d     = ST_IDLE;
                    load_done_d = 1'b1;
                    wr_ptr_d    = '0;
                    cnt_d       = '0;
                    asm_d       = '0;
                    if (cnt_new != 3'd0) begin
                        mem_we    = 1'b1;
                        mem_wdata = asm_pad;
                    end
                end else if (cnt_new == 3'd4) begin
                    mem_we    = 1'b1;
                    mem_wdata = asm_new;
                    wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    cnt_d     = '0;
                    asm_d     = '0;
                end else begin
                    cnt_d = cnt_new[1:0];
                    asm_d = asm_new;
                end
            end
            ST_SERVE: begin
                // load_en is deliberately not looked at here.
                if (ce == IFR_CE_ACTIVE) begin
                    fetch = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_valid_d = fetch;
        req_err_d   = fetch && fetch_err;
    end

    // Keep the RAM quiet in a reset cycle so an interrupted session never
    // commits its partial word.
    assign mem_re   = fetch && !rst;
    assign mem_addr = (state_q == ST_LOAD) ? wr_ptr_q : pc[INST_ADDR_W+1:2];

    inst_mem_sp #(
        .DEPTH (INST_MEM_DEPTH),
        .AW    (INST_ADDR_W),
        .DW    (32)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && !rst),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            req_valid_q <= 1'b0;
            req_err_q   <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            req_valid_q <= req_valid_d;
            req_err_q   <= req_err_d;
            load_done_q <= load_done_d;
        end
    end

    // RAM data is only meaningful for a valid, in-range request.
    assign inst       = (req_valid_q && !req_err_q) ? mem_rdata : IFR_NOP;
    assign inst_valid = req_valid_q;
    assign addr_err   = req_err_q;
    assign load_ready = (state_q == ST_LOAD);
    assign load_done  = load_done_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
module tb_inst_fetch_resp;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        addr_err;
    logic        load_en;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    resp_t       exp_q[$];
    logic [7:0]  ld_q[$];
    vec_t        vec[9];

    inst_fetch_resp #(
        .INST_MEM_DEPTH (1024),
        .INST_ADDR_W    (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .addr_err   (addr_err),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .load_done  (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and score any
    // response expected from the request presented in the cycle just ended.
    task automatic tick();
        resp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, e.v});
            chk("inst", inst, e.inst);
            chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
            $display("resp pc=%h inst=%h valid=%0d err=%0d", pc, inst, inst_valid, addr_err);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee);
        resp_t e;
        ce = 1'b1;
        pc = a;
        e.v = 1'b1; e.inst = ei; e.err = ee;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic fetch_off();
        resp_t e;
        ce = 1'b0;
        e.v = 1'b0; e.inst = 32'h0; e.err = 1'b0;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic push_word(input logic [31:0] w);
        ld_q.push_back(w[31:24]);
        ld_q.push_back(w[23:16]);
        ld_q.push_back(w[15:8]);
        ld_q.push_back(w[7:0]);
    endtask

    // Run a complete load session from IDLE with the bytes in ld_q.
    task automatic load_session();
        int n;
        n = ld_q.size();
        ce = 1'b0;
        load_en = 1'b1;
        load_valid = 1'b0;
        tick();
        chk("load_ready_in_load", {31'd0, load_ready}, 32'd1);
        while (ld_q.size() > 0) begin
            load_valid = 1'b1;
            load_byte  = ld_q.pop_front();
            tick();
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        tick();
        chk("load_done_pulse", {31'd0, load_done}, 32'd1);
        tick();
        chk("load_done_once", {31'd0, load_done}, 32'd0);
        chk("load_ready_after", {31'd0, load_ready}, 32'd0);
        $display("load session bytes=%0d done", n);
    endtask

    initial begin
        vec[0] = '{32'h0000_0000, 32'h3C01_0010, 1'b0};
        vec[1] = '{32'h0000_0004, 32'h3421_0001, 1'b0};
        vec[2] = '{32'h0000_0008, 32'h0000_0000, 1'b0};
        vec[3] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
        vec[4] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
        vec[5] = '{32'h0000_0004, 32'h3421_0001, 1'b0};
        vec[6] = '{32'h8000_0000, 32'h0000_0000, 1'b1};
        vec[7] = '{32'h0000_0003, 32'h0000_0000, 1'b1};
        vec[8] = '{32'h0000_0000, 32'h3C01_0010, 1'b0};

        rst = 1'b1; ce = 1'b0; pc = 32'h0;
        load_en = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
        tick(); tick(); tick();
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        rst = 1'b0;
        tick();

        // Known-zero contents for words 0..2.
        for (int i = 0; i < 3; i++) push_word(32'h0);
        load_session();

        // Two-word program, then the pipelined vector table.
        push_word(32'h3C01_0010);
        push_word(32'h3421_0001);
        load_session();
        for (int i = 0; i < 9; i++) fetch(vec[i].pc, vec[i].inst, vec[i].err);
        fetch_off();

        // Partial trailing word is zero-padded.
        ld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        load_session();
        fetch(32'h0, 32'hAABB_CCDD, 1'b0);
        fetch(32'h4, 32'hEEFF_0000, 1'b0);
        fetch(32'h8, 32'h0000_0000, 1'b0);
        fetch_off();

        // Reset two bytes into a session: nothing written, no done pulse.
        load_en = 1'b1; tick();
        load_valid = 1'b1; load_byte = 8'h11; tick();
        load_byte = 8'h22; tick();
        load_valid = 1'b0; load_en = 1'b0; rst = 1'b1; tick();
        chk("rst_load_no_done", {31'd0, load_done}, 32'd0);
        rst = 1'b0; tick();
        chk("rst_load_no_done2", {31'd0, load_done}, 32'd0);
        chk("rst_load_idle", {31'd0, load_ready}, 32'd0);
        fetch(32'h0, 32'hAABB_CCDD, 1'b0);
        fetch(32'h4, 32'hEEFF_0000, 1'b0);
        fetch_off();
        push_word(32'h1234_5678);
        load_session();
        fetch(32'h0, 32'h1234_5678, 1'b0);
        fetch(32'h4, 32'hEEFF_0000, 1'b0);
        fetch_off();

        // load_en during SERVE is ignored until the FSM is back in IDLE.
        load_en = 1'b0;
        fetch(32'h0, 32'h1234_5678, 1'b0);
        load_en = 1'b1;
        fetch(32'h4, 32'hEEFF_0000, 1'b0);
        chk("serve_no_ready1", {31'd0, load_ready}, 32'd0);
        fetch(32'h8, 32'h0000_0000, 1'b0);
        chk("serve_no_ready2", {31'd0, load_ready}, 32'd0);
        fetch_off();
        chk("idle_no_ready", {31'd0, load_ready}, 32'd0);
        tick();
        chk("enter_load_ready", {31'd0, load_ready}, 32'd1);
        load_en = 1'b0; tick();
        chk("empty_session_done", {31'd0, load_done}, 32'd1);
        tick();
        fetch(32'h0, 32'h1234_5678, 1'b0);
        fetch_off();

        // Reset with a fetch pending: the response is suppressed.
        begin
            resp_t e;
            ce = 1'b1; pc = 32'h0; rst = 1'b1;
            e.v = 1'b0; e.inst = 32'h0; e.err = 1'b0;
            exp_q.push_back(e);
            tick();
            rst = 1'b0;
            fetch_off();
        end

        // Fill all 1024 words plus one: the extra word wraps onto word 0.
        for (int i = 0; i < 1024; i++) push_word(32'hC0DE_0000 | i);
        push_word(32'h5A5A_5A5A);
        load_session();
        fetch(32'h0000_0000, 32'h5A5A_5A5A, 1'b0);
        fetch(32'h0000_0004, 32'hC0DE_0001, 1'b0);
        fetch(32'h0000_0FFC, 32'hC0DE_03FF, 1'b0);
        fetch(32'h0000_1000, 32'h0000_0000, 1'b1);
        fetch_off();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
